// File: rtl/rsp_router.sv
// Response router: remembers which port each accepted grant belongs to and
// steers in-order responses back to that port through a single output register.
module rsp_router #(
    parameter int unsigned REQ_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PW         = $clog2(REQ_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_vld,
    input  logic [PW-1:0]               issue_port,
    output logic                        issue_rdy,
    input  logic                        rsp_vld,
    input  logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        rsp_rdy,
    output logic [REQ_WIDTH-1:0]        out_vld,
    output logic [PW-1:0]               out_port,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic [REQ_WIDTH-1:0]        out_rdy,
    output logic [$clog2(DEPTH):0]      outstanding,
    output logic                        err_orphan
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PW-1:0] tag_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          obuf_vld;
    logic          obuf_free;
    logic          push;
    logic          pop;

    // Ready signals come from registered state only; no bypass on full or empty.
    assign issue_rdy   = (count < CW'(DEPTH));
    assign obuf_free   = !obuf_vld || out_rdy[out_port];
    assign rsp_rdy     = (count != '0) && obuf_free;
    assign push        = issue_vld && issue_rdy;
    assign pop         = rsp_vld && rsp_rdy;
    assign outstanding = count;
    assign out_vld     = obuf_vld ? (REQ_WIDTH'(1) << out_port) : '0;

    // Tag storage is never reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= issue_port;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            obuf_vld   <= 1'b0;
            out_port   <= '0;
            out_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A pop reloads the output register even while it drains, giving 1 rsp/cycle.
            if (pop) begin
                obuf_vld <= 1'b1;
                out_port <= tag_mem[rd_ptr];
                out_data <= rsp_data;
            end else if (obuf_vld && out_rdy[out_port]) begin
                obuf_vld <= 1'b0;
            end
            if (rsp_vld && (count == '0)) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rsp_router.md
RSP_ROUTER -- requirements
Module: rsp_router

Interface
REQ-001 Parameter REQ_WIDTH, default 16: number of requester ports.
REQ-002 Parameter DATA_WIDTH, default 32: response data width.
REQ-003 Parameter DEPTH, default 8, power of two ≥2: maximum outstanding grants.
REQ-004 Parameter PW = $clog2(REQ_WIDTH), derived: port-index width.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 issue_vld  input  1  arbiter grant accepted this cycle (same pulse that drives the arbiter's en).
REQ-008 issue_port  input  PW  granted port index, qualified by issue_vld.
REQ-009 issue_rdy  output  1  tag FIFO can accept an issue.
REQ-010 rsp_vld  input  1  shared resource presents a response.
REQ-011 rsp_data  input  DATA_WIDTH  response payload.
REQ-012 rsp_rdy  output  1  response accepted when rsp_vld & rsp_rdy.
REQ-013 out_vld  output  REQ_WIDTH  one-hot valid to the owning requester.
REQ-014 out_port  output  PW  index of the port addressed by out_vld.
REQ-015 out_data  output  DATA_WIDTH  response payload, shared by all ports.
REQ-016 out_rdy  input  REQ_WIDTH  per-port ready; only out_rdy[out_port] is used.
REQ-017 outstanding  output  $clog2(DEPTH)+1  number of tags in the FIFO.
REQ-018 err_orphan  output  1  sticky flag: a response arrived with no outstanding tag.

Function
REQ-019 Block returns in-order responses to the port that issued the matching grant; a DEPTH-entry circular FIFO holds port tags.
REQ-020 Push: issue_vld & issue_rdy writes issue_port at the write pointer, and the write pointer increments modulo DEPTH.
REQ-021 issue_rdy = (outstanding < DEPTH), combinational from registered count only; no full-bypass on a same-cycle pop.
REQ-022 issue_vld while issue_rdy=0: ignored, with no state change.
REQ-023 Output stage: single register (obuf_vld, out_port, out_data).
REQ-024 Output stage is "free" when obuf_vld=0 or out_rdy[out_port]=1.
REQ-025 rsp_rdy = (outstanding != 0) & output stage free; no empty-bypass, so a tag pushed in cycle N first serves a response in cycle N+1.
REQ-026 Pop: rsp_vld & rsp_rdy reads the tag at the read pointer.
REQ-027 On pop, the read pointer increments modulo DEPTH, and the next cycle loads obuf with {1, tag, rsp_data}.
REQ-028 Latency: exactly 1 cycle from accepted response to out_vld.
REQ-029 out_vld = obuf_vld ? (1 << out_port) : 0; never more than one bit set.
REQ-030 Output handshake: obuf clears when obuf_vld & out_rdy[out_port] and no new pop occurs that cycle.
REQ-031 Back-to-back: pop and drain in the same cycle reloads obuf, sustaining 1 response/cycle.
REQ-032 While out_rdy[out_port]=0, obuf holds and rsp_rdy=0; out_port, out_data and out_vld stay stable.
REQ-033 outstanding: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
REQ-034 outstanding ranges 0..DEPTH.
REQ-035 Pointer wrap: DEPTH−1 → 0 with no bubble.
REQ-036 Orphan: rsp_vld=1 while outstanding=0 sets err_orphan=1 until reset.
REQ-037 An orphan response is not accepted (rsp_rdy=0) and does not change pointers, the count or obuf.
REQ-038 Ports other than out_port are ignored for out_rdy; their values have no effect.

Reset
REQ-039 Reset clears the read and write pointers, outstanding, obuf_vld and err_orphan.
REQ-040 In reset: issue_rdy=1 (after reset with DEPTH≥1), rsp_rdy=0, out_vld=0, out_port=0, out_data=0.
REQ-041 Reset mid-operation discards all outstanding tags and any held output immediately and asynchronously; FIFO storage contents need not be cleared.
REQ-042 First push is legal on the first clock edge after rst deasserts.

Verification
REQ-043 Single: issue port 5, next cycle rsp_data=0xA5A5_0001, out_rdy=all 1 → one cycle later out_vld=0x0020, out_port=5, out_data=0xA5A5_0001; outstanding 1→0.
REQ-044 Order: issue ports 3,0,15, then 3 responses D0..D2 back-to-back → out_vld 0x0008/0x0001/0x8000 on consecutive cycles, carrying D0,D1,D2.
REQ-045 Full/wrap: issue 8 tags → issue_rdy=0 and a ninth issue is ignored; 8 responses are returned in order.
REQ-045a Full/wrap, continued: 20 more issue/response pairs interleaved → correct ports across pointer wrap, with outstanding never exceeding 8.
REQ-046 Backpressure: out_rdy[7]=0 with a port-7 response held → rsp_rdy=0 and out_data stable for 5 cycles; release → drained in 1 cycle, next response follows the next cycle.
REQ-047 Orphan/reset: rsp_vld with outstanding=0 → err_orphan=1, rsp_rdy=0; assert rst with 4 tags outstanding and obuf valid → outstanding=0, out_vld=0, err_orphan=0 immediately.
